// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and FSM encoding for the FND display path
package fnd_pkg;

  localparam int DIGIT_W = 4;

  // Double-dabble correction: digits at or above this value get +3 before shifting
  localparam logic [DIGIT_W-1:0] BCD_ADD3_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ADD3_VAL    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - combinational "if >= 5 add 3" correction for one BCD digit
module bcd_add3_digit
  import fnd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // 4-bit add with no carry out; a corrected digit never exceeds 12
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADD3_THRESH) begin
      digit_o = digit_i + BCD_ADD3_VAL;
    end
  end

endmodule

// File: rtl/bcd_splitter_seq.sv
// rtl/bcd_splitter_seq.sv - iterative binary-to-BCD splitter with handshake, overflow and blank mask
module bcd_splitter_seq
  import fnd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [BIN_W-1:0]          i_bin,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [DIGIT_W*DIGITS-1:0] o_bcd,
  output logic                      o_overflow,
  output logic [DIGITS-1:0]         o_blank
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q;
  logic [BIN_W-1:0]   shreg_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic [BIN_W-1:0]   shreg_d;
  logic               ovf_d;
  logic [DIGITS-1:0]  blank_d;

  // Per-digit add-3 correction applied to the accumulator before each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One double-dabble step: the bit leaving the top digit feeds the sticky overflow
  always_comb begin
    acc_d   = {acc_adj[ACC_W-2:0], shreg_q[BIN_W-1]};
    shreg_d = shreg_q << 1;
    ovf_d   = ovf_q | acc_adj[ACC_W-1];
  end

  // Leading-zero mask: scan from the top digit down; the ones digit is never blanked
  always_comb begin
    logic all_zero;
    blank_d  = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (acc_q[k*DIGIT_W +: DIGIT_W] == '0);
      blank_d[k] = all_zero;
    end
  end

  // Control FSM plus datapath registers; results are only published in DONE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      o_valid    <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
      o_blank    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            shreg_q <= i_bin;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_W'(BIN_W);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          ovf_q   <= ovf_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_bcd      <= acc_q;
          o_overflow <= ovf_q;
          o_blank    <= blank_d;
          o_valid    <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_bcd_splitter_seq.sv
// tb/tb_bcd_splitter_seq.sv - directed self-checking bench for bcd_splitter_seq
module tb_bcd_splitter_seq;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rst, vld;
  logic [13:0] bin;
  logic        rdy, ovld, ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;

  logic        rst6, vld6;
  logic [16:0] bin6;
  logic        rdy6, ovld6, ovf6;
  logic [23:0] bcd6;
  logic [5:0]  blank6;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bcd_splitter_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_bin(bin),
    .o_ready(rdy), .o_valid(ovld), .o_bcd(bcd), .o_overflow(ovf), .o_blank(blank)
  );

  bcd_splitter_seq #(.BIN_W(17), .DIGITS(6)) dut6 (
    .i_clk(clk), .i_reset(rst6), .i_valid(vld6), .i_bin(bin6),
    .o_ready(rdy6), .o_valid(ovld6), .o_bcd(bcd6), .o_overflow(ovf6), .o_blank(blank6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for o_valid of the selected instance; returns cycle stamp or -1
  task automatic wait_valid(input bit sel6, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < 60) begin
      if ((sel6 ? ovld6 : ovld) === 1'b1) begin
        at = cyc;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issues one request, scrambles i_bin after the accept, returns latency in cycles
  task automatic run14(input logic [13:0] v, output int lat);
    int t0, at;
    @(negedge clk);
    check("ready_before_accept", {31'd0, rdy}, 32'd1);
    vld = 1'b1;
    bin = v;
    @(posedge clk); #1;
    t0  = cyc;
    vld = 1'b0;
    bin = 14'($urandom);
    wait_valid(1'b0, at);
    lat = (at < 0) ? -1 : at - t0;
  endtask

  task automatic run17(input logic [16:0] v, output int lat);
    int t0, at;
    @(negedge clk);
    vld6 = 1'b1;
    bin6 = v;
    @(posedge clk); #1;
    t0   = cyc;
    vld6 = 1'b0;
    bin6 = 17'($urandom);
    wait_valid(1'b1, at);
    lat = (at < 0) ? -1 : at - t0;
  endtask

  initial begin
    int lat, t0, t1, t2, pulses;
    rst = 1'b1; vld = 1'b0; bin = '0;
    rst6 = 1'b1; vld6 = 1'b0; bin6 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, rdy}, 32'd1);
    check("rst_valid", {31'd0, ovld}, 32'd0);
    check("rst_bcd", {16'd0, bcd}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_blank", {28'd0, blank}, 32'd0);
    check("rst6_ready", {31'd0, rdy6}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rst6 = 1'b0;

    run14(14'd1234, lat);
    check("1234_latency", lat, 32'd15);
    check("1234_bcd", {16'd0, bcd}, 32'h1234);
    check("1234_ovf", {31'd0, ovf}, 32'd0);
    check("1234_blank", {28'd0, blank}, 32'b0000);
    @(posedge clk); #1;
    check("1234_valid_single", {31'd0, ovld}, 32'd0);
    check("1234_ready_after", {31'd0, rdy}, 32'd1);

    run14(14'd0, lat);
    check("0_bcd", {16'd0, bcd}, 32'h0000);
    check("0_blank", {28'd0, blank}, 32'b1110);
    check("0_ovf", {31'd0, ovf}, 32'd0);

    run14(14'd9999, lat);
    check("9999_bcd", {16'd0, bcd}, 32'h9999);
    check("9999_blank", {28'd0, blank}, 32'b0000);

    run14(14'd12345, lat);
    check("12345_bcd", {16'd0, bcd}, 32'h2345);
    check("12345_ovf", {31'd0, ovf}, 32'd1);

    run14(14'd42, lat);
    check("42_bcd", {16'd0, bcd}, 32'h0042);
    check("42_ovf", {31'd0, ovf}, 32'd0);
    check("42_blank", {28'd0, blank}, 32'b1100);

    // Request during SHIFT must be ignored; previous result must hold meanwhile
    @(negedge clk);
    vld = 1'b1;
    bin = 14'd777;
    @(posedge clk); #1;
    t0  = cyc;
    vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_ready", {31'd0, rdy}, 32'd0);
    vld = 1'b1;
    bin = 14'd500;
    @(negedge clk);
    vld = 1'b0;
    check("hold_bcd", {16'd0, bcd}, 32'h0042);
    #1;
    wait_valid(1'b0, t1);
    check("777_latency", (t1 < 0) ? -1 : t1 - t0, 32'd15);
    check("777_bcd", {16'd0, bcd}, 32'h0777);
    check("777_blank", {28'd0, blank}, 32'b1000);
    @(posedge clk); #1;
    repeat (20) begin
      @(posedge clk); #1;
      if (ovld) pulses++;
    end
    check("ignored_no_extra", pulses, 32'd0);

    // Held i_valid: accepts are spaced BIN_W+2 cycles
    @(negedge clk);
    vld = 1'b1;
    bin = 14'd100;
    #1;
    wait_valid(1'b0, t1);
    @(posedge clk); #1;
    wait_valid(1'b0, t2);
    @(negedge clk);
    vld = 1'b0;
    check("b2b_spacing", (t1 < 0 || t2 < 0) ? -1 : t2 - t1, 32'd16);
    check("b2b_bcd", {16'd0, bcd}, 32'h0100);

    // Reset in the middle of SHIFT abandons the conversion
    @(negedge clk);
    vld = 1'b1;
    bin = 14'd555;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'd0, ovld}, 32'd0);
    check("midrst_bcd", {16'd0, bcd}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_blank", {28'd0, blank}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", {31'd0, rdy}, 32'd1);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (ovld) pulses++;
    end
    check("midrst_no_valid", pulses, 32'd0);

    // Wider configuration
    run17(17'd131071, lat);
    check("131071_latency", lat, 32'd18);
    check("131071_bcd", {8'd0, bcd6}, 32'h131071);
    check("131071_blank", {26'd0, blank6}, 32'b000000);
    check("131071_ovf", {31'd0, ovf6}, 32'd0);

    run17(17'd1000, lat);
    check("1000_bcd", {8'd0, bcd6}, 32'h001000);
    check("1000_blank", {26'd0, blank6}, 32'b110000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
